// File: rtl/player_motion_ctrl_if.sv
// Wall-collision checker handshake between player_motion_ctrl (master) and the checker (slave).
interface player_motion_ctrl_if;
  logic        chk_req;
  logic [10:0] chk_x;
  logic [10:0] chk_y;
  logic        chk_ack;
  logic        chk_hit;

  modport master (output chk_req, chk_x, chk_y, input chk_ack, chk_hit);
  modport slave  (input chk_req, chk_x, chk_y, output chk_ack, chk_hit);
endinterface

// File: rtl/player_motion_ctrl.sv
// Per-frame player motion scheduler: samples a move at vblank start, arbitrates it against a wall checker.
// Define PLAYER_WRAP_EN to wrap out-of-range candidates instead of clamping them.
module player_motion_ctrl #(
  parameter int HLINES      = 640,
  parameter int VLINES      = 480,
  parameter int OBJ_W       = 40,
  parameter int OBJ_H       = 40,
  parameter int START_X     = 300,
  parameter int START_Y     = 220,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                        i_pixel_clk,
  input  logic                        i_reset,
  input  logic [10:0]                 i_hcounter,
  input  logic [10:0]                 i_vcounter,
  input  logic                        i_move_valid,
  input  logic [5:0]                  i_move_dx,
  input  logic [5:0]                  i_move_dy,
  player_motion_ctrl_if.master        chk,
  output logic [10:0]                 o_pos_x,
  output logic [10:0]                 o_pos_y,
  output logic                        o_busy,
  output logic                        o_frame_done
);

  // state     | meaning
  // IDLE      | wait for frame trigger      SAMPLE | latch command, form candidate
  // CHK_XY/X/Y| checker handshake per axis  COMMIT | load position, pulse frame_done
  typedef enum logic [2:0] {
    ST_IDLE, ST_SAMPLE, ST_CHK_XY, ST_CHK_X, ST_CHK_Y, ST_COMMIT
  } state_t;

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic signed [11:0] X_MAX = 12'(HLINES - OBJ_W);
  localparam logic signed [11:0] Y_MAX = 12'(VLINES - OBJ_H);

  state_t r_state, w_state_nxt;

  logic [10:0]   r_pos_x, r_pos_y;
  logic [10:0]   r_cx, r_cy;
  logic [10:0]   r_new_x, r_new_y;
  logic          r_chk_req;
  logic [10:0]   r_chk_x, r_chk_y;
  logic [TW-1:0] r_tmo;

  logic               w_trigger;
  logic signed [11:0] w_sum_x, w_sum_y;
  logic [10:0]        w_cx, w_cy;
  logic               w_move;
  logic               w_in_chk;
  logic               w_chk_done;
  logic               w_blocked;
  logic               w_enter;
  logic [10:0]        w_nxt_x, w_nxt_y;

  function automatic logic [10:0] f_fit(input logic signed [11:0] v,
                                        input logic signed [11:0] lim);
`ifdef PLAYER_WRAP_EN
    if (v < 12'sd0)
      f_fit = 11'(v + lim + 12'sd1);
    else if (v > lim)
      f_fit = 11'(v - lim - 12'sd1);
    else
      f_fit = 11'(v);
`else
    if (v < 12'sd0)
      f_fit = '0;
    else if (v > lim)
      f_fit = 11'(lim);
    else
      f_fit = 11'(v);
`endif
  endfunction

  assign w_trigger = (i_hcounter == 11'd0) && (i_vcounter == 11'(VLINES));
  assign w_sum_x   = $signed({1'b0, r_pos_x}) + $signed({{6{i_move_dx[5]}}, i_move_dx});
  assign w_sum_y   = $signed({1'b0, r_pos_y}) + $signed({{6{i_move_dy[5]}}, i_move_dy});
  assign w_cx      = f_fit(w_sum_x, X_MAX);
  assign w_cy      = f_fit(w_sum_y, Y_MAX);
  assign w_move    = i_move_valid && ((w_cx != r_pos_x) || (w_cy != r_pos_y));

  always_ff @(posedge i_pixel_clk) begin
    if (i_reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_trigger) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = w_move ? ST_CHK_XY : ST_COMMIT;
      ST_CHK_XY: if (w_chk_done)
                   w_state_nxt = !w_blocked ? ST_COMMIT :
                                 (r_cx != r_pos_x) ? ST_CHK_X : ST_CHK_Y;
      ST_CHK_X:  if (w_chk_done)
                   w_state_nxt = (w_blocked && (r_cy != r_pos_y)) ? ST_CHK_Y : ST_COMMIT;
      ST_CHK_Y:  if (w_chk_done) w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy       = (r_state != ST_IDLE);
    o_frame_done = (r_state == ST_COMMIT);
    w_in_chk     = (r_state == ST_CHK_XY) || (r_state == ST_CHK_X) || (r_state == ST_CHK_Y);
    // ack only counts in a request-high cycle; the timer ends a silent check
    w_chk_done   = w_in_chk && r_chk_req && (chk.chk_ack || (r_tmo == '0));
    w_blocked    = chk.chk_ack ? chk.chk_hit : 1'b1;
    w_enter      = (w_state_nxt != r_state) &&
                   ((w_state_nxt == ST_CHK_XY) || (w_state_nxt == ST_CHK_X) ||
                    (w_state_nxt == ST_CHK_Y));
    w_nxt_x      = r_pos_x;
    w_nxt_y      = r_pos_y;
    case (w_state_nxt)
      ST_CHK_XY: begin w_nxt_x = w_cx;    w_nxt_y = w_cy;    end
      ST_CHK_X:  begin w_nxt_x = r_cx;    w_nxt_y = r_pos_y; end
      ST_CHK_Y:  begin w_nxt_x = r_pos_x; w_nxt_y = r_cy;    end
      default:   ;
    endcase
  end

  always_ff @(posedge i_pixel_clk) begin
    if (i_reset) begin
      r_pos_x   <= 11'(START_X);
      r_pos_y   <= 11'(START_Y);
      r_cx      <= '0;
      r_cy      <= '0;
      r_new_x   <= 11'(START_X);
      r_new_y   <= 11'(START_Y);
      r_chk_req <= 1'b0;
      r_chk_x   <= '0;
      r_chk_y   <= '0;
      r_tmo     <= '0;
    end else begin
      case (r_state)
        ST_SAMPLE: begin
          r_cx    <= w_cx;
          r_cy    <= w_cy;
          r_new_x <= r_pos_x;
          r_new_y <= r_pos_y;
        end
        ST_CHK_XY: if (w_chk_done && !w_blocked) begin r_new_x <= r_cx; r_new_y <= r_cy; end
        ST_CHK_X:  if (w_chk_done && !w_blocked) begin r_new_x <= r_cx; r_new_y <= r_pos_y; end
        ST_CHK_Y:  if (w_chk_done && !w_blocked) begin r_new_x <= r_pos_x; r_new_y <= r_cy; end
        ST_COMMIT: begin r_pos_x <= r_new_x; r_pos_y <= r_new_y; end
        default: ;
      endcase

      // request stays low in the entry cycle so successive checks are separated
      if (w_enter) begin
        r_chk_x   <= w_nxt_x;
        r_chk_y   <= w_nxt_y;
        r_chk_req <= 1'b0;
        r_tmo     <= TW'(ACK_TIMEOUT - 1);
      end else if (w_in_chk) begin
        if (!r_chk_req)
          r_chk_req <= 1'b1;
        else if (w_chk_done)
          r_chk_req <= 1'b0;
        else
          r_tmo <= r_tmo - 1'b1;
      end
    end
  end

  assign chk.chk_req = r_chk_req;
  assign chk.chk_x   = r_chk_x;
  assign chk.chk_y   = r_chk_y;
  assign o_pos_x     = r_pos_x;
  assign o_pos_y     = r_pos_y;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl with a scripted wall checker and a handshake monitor.
module tb_player_motion_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hc, vc;
  logic        mv;
  logic [5:0]  dx, dy;
  logic [10:0] px, py;
  logic        busy, fd;

  always #20 clk = ~clk;

  player_motion_ctrl_if chk();

  player_motion_ctrl dut (
    .i_pixel_clk (clk),
    .i_reset     (rst),
    .i_hcounter  (hc),
    .i_vcounter  (vc),
    .i_move_valid(mv),
    .i_move_dx   (dx),
    .i_move_dy   (dy),
    .chk         (chk),
    .o_pos_x     (px),
    .o_pos_y     (py),
    .o_busy      (busy),
    .o_frame_done(fd)
  );

  int n_vec = 0;
  int n_err = 0;

  // scripted checker
  logic        cfg_noack = 1'b0, blk_en = 1'b0, nack_en = 1'b0, late_ack = 1'b0;
  logic [10:0] bx = '0, by = '0, nx = '0, ny = '0;

  always @(negedge clk) begin
    if (late_ack) begin
      chk.chk_ack = 1'b1;
      chk.chk_hit = 1'b0;
    end else if (chk.chk_req === 1'b1 && !cfg_noack &&
                 !(nack_en && chk.chk_x == nx && chk.chk_y == ny)) begin
      chk.chk_ack = 1'b1;
      chk.chk_hit = blk_en && chk.chk_x == bx && chk.chk_y == by;
    end else begin
      chk.chk_ack = 1'b0;
      chk.chk_hit = 1'b0;
    end
  end

  // handshake monitor, sampled just after each rising edge
  int req_rises, min_gap, high_min, high_max, addr_changes, fd_count;
  int low_run = 0, high_run = 0;
  logic        prev_req = 1'b0;
  logic [10:0] prev_x = '0, prev_y = '0;

  always begin
    @(posedge clk);
    #1;
    if (fd === 1'b1) fd_count++;
    if (chk.chk_req === 1'b1) begin
      if (!prev_req) begin
        req_rises++;
        if (req_rises > 1 && low_run < min_gap) min_gap = low_run;
        high_run = 1;
      end else begin
        high_run++;
        if (chk.chk_x !== prev_x || chk.chk_y !== prev_y) addr_changes++;
      end
    end else begin
      if (prev_req) begin
        if (high_run < high_min) high_min = high_run;
        if (high_run > high_max) high_max = high_run;
        low_run = 1;
      end else begin
        low_run++;
      end
    end
    prev_req = (chk.chk_req === 1'b1);
    prev_x   = chk.chk_x;
    prev_y   = chk.chk_y;
  end

  task automatic clr_stats;
    req_rises = 0; min_gap = 1000; high_min = 1000; high_max = 0;
    addr_changes = 0; fd_count = 0;
  endtask

  task automatic do_reset;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // returns at the falling edge of the SAMPLE cycle (T+1)
  task automatic pulse_trigger;
    @(negedge clk); hc = 11'd0; vc = 11'd480;
    @(negedge clk); hc = 11'd1;
  endtask

  task automatic run_frame(input int sdx, input int sdy, output bit ok);
    mv = 1'b1; dx = 6'(sdx); dy = 6'(sdy);
    pulse_trigger();
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (fd === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    hc = 11'd300; vc = 11'd100;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_vec++; if (px !== 11'd300) begin n_err++; $display("FAIL reset_pos_x: got %0d want 300", px); end
    n_vec++; if (py !== 11'd220) begin n_err++; $display("FAIL reset_pos_y: got %0d want 220", py); end
    n_vec++; if (chk.chk_req !== 1'b0 || busy !== 1'b0 || fd !== 1'b0)
      begin n_err++; $display("FAIL reset_ctrl: req=%b busy=%b fd=%b want 000", chk.chk_req, busy, fd); end
    n_vec++; if (chk.chk_x !== 11'd0 || chk.chk_y !== 11'd0)
      begin n_err++; $display("FAIL reset_chk_addr: got (%0d,%0d) want (0,0)", chk.chk_x, chk.chk_y); end
    rst = 1'b0;
  endtask

  task automatic test_idle_frame;
    clr_stats();
    mv = 1'b0; dx = 6'd5; dy = 6'd5;
    pulse_trigger();
    n_vec++; if (busy !== 1'b1 || fd !== 1'b0)
      begin n_err++; $display("FAIL idle_t1: busy=%b fd=%b want busy=1 fd=0", busy, fd); end
    @(negedge clk);
    n_vec++; if (fd !== 1'b1) begin n_err++; $display("FAIL idle_fd_t2: got %b want 1", fd); end
    @(negedge clk);
    n_vec++; if (fd !== 1'b0 || busy !== 1'b0)
      begin n_err++; $display("FAIL idle_t3: fd=%b busy=%b want 0 0", fd, busy); end
    n_vec++; if (px !== 11'd300 || py !== 11'd220)
      begin n_err++; $display("FAIL idle_pos: got (%0d,%0d) want (300,220)", px, py); end
    n_vec++; if (req_rises !== 0) begin n_err++; $display("FAIL idle_no_req: got %0d want 0", req_rises); end
  endtask

  task automatic test_clear_move;
    clr_stats();
    mv = 1'b1; dx = 6'd5; dy = 6'b111101;
    pulse_trigger();
    @(negedge clk);
    n_vec++; if (chk.chk_req !== 1'b0) begin n_err++; $display("FAIL clr_req_t2: got %b want 0", chk.chk_req); end
    n_vec++; if (chk.chk_x !== 11'd305 || chk.chk_y !== 11'd217)
      begin n_err++; $display("FAIL clr_addr: got (%0d,%0d) want (305,217)", chk.chk_x, chk.chk_y); end
    @(negedge clk);
    n_vec++; if (chk.chk_req !== 1'b1) begin n_err++; $display("FAIL clr_req_t3: got %b want 1", chk.chk_req); end
    @(negedge clk);
    n_vec++; if (fd !== 1'b1 || px !== 11'd300)
      begin n_err++; $display("FAIL clr_t4: fd=%b px=%0d want fd=1 px=300", fd, px); end
    @(negedge clk);
    n_vec++; if (px !== 11'd305 || py !== 11'd217)
      begin n_err++; $display("FAIL clr_pos_t5: got (%0d,%0d) want (305,217)", px, py); end
    repeat (2) @(negedge clk);
    n_vec++; if (fd_count !== 1 || req_rises !== 1)
      begin n_err++; $display("FAIL clr_counts: fd=%0d req=%0d want 1 1", fd_count, req_rises); end
  endtask

  task automatic test_slide_x;
    bit ok;
    do_reset();
    blk_en = 1'b1; bx = 11'd304; by = 11'd224;
    clr_stats();
    run_frame(4, 4, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL slide_done: frame_done not seen within 400 cycles"); end
    n_vec++; if (px !== 11'd304 || py !== 11'd220)
      begin n_err++; $display("FAIL slide_pos: got (%0d,%0d) want (304,220)", px, py); end
    n_vec++; if (req_rises !== 2 || min_gap < 1)
      begin n_err++; $display("FAIL slide_req: rises=%0d gap=%0d want 2 >=1", req_rises, min_gap); end
    n_vec++; if (addr_changes !== 0 || fd_count !== 1)
      begin n_err++; $display("FAIL slide_stable: addr_chg=%0d fd=%0d want 0 1", addr_changes, fd_count); end
    blk_en = 1'b0;
  endtask

  task automatic test_timeout;
    bit ok;
    cfg_noack = 1'b1;
    clr_stats();
    run_frame(4, 4, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL tmo_done: frame_done not seen within 400 cycles"); end
    n_vec++; if (px !== 11'd304 || py !== 11'd220)
      begin n_err++; $display("FAIL tmo_pos: got (%0d,%0d) want (304,220)", px, py); end
    n_vec++; if (req_rises !== 3) begin n_err++; $display("FAIL tmo_checks: got %0d want 3", req_rises); end
    n_vec++; if (high_min !== 64 || high_max !== 64)
      begin n_err++; $display("FAIL tmo_len: min=%0d max=%0d want 64 64", high_min, high_max); end
    n_vec++; if (fd_count !== 1) begin n_err++; $display("FAIL tmo_fd: got %0d want 1", fd_count); end
    cfg_noack = 1'b0;
  endtask

  task automatic test_clamp_wrap;
    int seq_dx [10] = '{31, 31, 31, 31, 31, 31, 31, 31, 31, 19};
    int seq_dy [10] = '{-32, -32, -32, -32, -32, -32, -28, 0, 0, 0};
    int n_ok;
    bit ok;
    logic [10:0] ex, ey;
    do_reset();
    n_ok = 0;
    for (int i = 0; i < 10; i++) begin
      run_frame(seq_dx[i], seq_dy[i], ok);
      if (ok) n_ok++;
    end
    n_vec++; if (n_ok !== 10) begin n_err++; $display("FAIL walk_frames: got %0d want 10", n_ok); end
    n_vec++; if (px !== 11'd598 || py !== 11'd0)
      begin n_err++; $display("FAIL walk_pos: got (%0d,%0d) want (598,0)", px, py); end
`ifdef PLAYER_WRAP_EN
    ex = 11'd7;   ey = 11'd433;
`else
    ex = 11'd600; ey = 11'd0;
`endif
    run_frame(10, -8, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL edge_done: frame_done not seen within 400 cycles"); end
    n_vec++; if (px !== ex || py !== ey)
      begin n_err++; $display("FAIL edge_pos: got (%0d,%0d) want (%0d,%0d)", px, py, ex, ey); end
  endtask

  task automatic test_reset_mid_check;
    bit found;
    do_reset();
    blk_en = 1'b1; bx = 11'd304; by = 11'd224;
    nack_en = 1'b1; nx = 11'd304; ny = 11'd220;
    mv = 1'b1; dx = 6'd4; dy = 6'd4;
    pulse_trigger();
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (chk.chk_req === 1'b1 && chk.chk_x == 11'd304 && chk.chk_y == 11'd220) begin
        found = 1'b1; break;
      end
      @(negedge clk);
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL midchk_reach: X-only request not seen within 50 cycles"); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (chk.chk_req !== 1'b0 || busy !== 1'b0)
      begin n_err++; $display("FAIL midchk_ctrl: req=%b busy=%b want 0 0", chk.chk_req, busy); end
    n_vec++; if (px !== 11'd300 || py !== 11'd220 || chk.chk_x !== 11'd0)
      begin n_err++; $display("FAIL midchk_pos: got (%0d,%0d) chk_x=%0d want (300,220) 0", px, py, chk.chk_x); end
    rst = 1'b0;
    clr_stats();
    late_ack = 1'b1;
    repeat (3) @(negedge clk);
    late_ack = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0 || fd_count !== 0 || px !== 11'd300)
      begin n_err++; $display("FAIL midchk_late_ack: busy=%b fd=%0d px=%0d want 0 0 300", busy, fd_count, px); end
    blk_en = 1'b0; nack_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hc = 11'd5; vc = 11'd0; mv = 1'b0; dx = '0; dy = '0;
    clr_stats();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_idle_frame();
    test_clear_move();
    test_slide_x();
    test_timeout();
    test_clamp_wrap();
    test_reset_mid_check();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
